// File: rtl/neuron_weight_sequencer.sv
// Weight-set scheduler for one neuron: applies each non-empty table entry for a
// programmable epoch, counts output spikes per epoch; host writes stall only on the active entry.
module neuron_weight_sequencer #(
  parameter int WW    = 4,
  parameter int NSETS = 4,
  parameter int EPW   = 8,
  localparam int AW   = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic           cfg_we,
  input  logic [AW-1:0]  cfg_addr,
  input  logic [WW-1:0]  cfg_w1,
  input  logic [WW-1:0]  cfg_w2,
  input  logic [WW-1:0]  cfg_w3,
  input  logic [2:0]     cfg_de,
  output logic           cfg_ready,
  input  logic [EPW-1:0] epoch_len,
  input  logic           start,
  input  logic           stop,
  input  logic           spike_in,
  output logic [WW-1:0]  W1,
  output logic [WW-1:0]  W2,
  output logic [WW-1:0]  W3,
  output logic           DE1,
  output logic           DE2,
  output logic           DE3,
  output logic [AW-1:0]  set_idx,
  output logic           busy,
  output logic           epoch_done,
  output logic [EPW-1:0] spike_count
);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_RUN} state_t;

  localparam logic [EPW-1:0] ONE = EPW'(1);

  state_t         state_q;
  logic [WW-1:0]  tab_w1_q [NSETS];
  logic [WW-1:0]  tab_w2_q [NSETS];
  logic [WW-1:0]  tab_w3_q [NSETS];
  logic [2:0]     tab_de_q [NSETS];

  logic [AW-1:0]  set_idx_q;
  logic [EPW-1:0] cnt_q;
  logic [EPW-1:0] acc_q;
  logic [EPW-1:0] spike_count_q;
  logic [WW-1:0]  w1_q, w2_q, w3_q;
  logic [2:0]     de_q;

  logic           any_set;
  logic [AW-1:0]  first_idx;
  logic [AW-1:0]  next_idx;
  logic [AW-1:0]  cand;
  logic           wr_ok;
  logic           last_cyc;
  logic [EPW-1:0] acc_d;
  logic [EPW-1:0] len_d;

  assign busy        = (state_q != S_IDLE);
  assign cfg_ready   = !(busy && (cfg_addr == set_idx_q));
  assign wr_ok       = cfg_we && cfg_ready;
  assign last_cyc    = (state_q == S_RUN) && (cnt_q == ONE);
  assign epoch_done  = last_cyc && !stop;
  assign acc_d       = (spike_in && (acc_q != '1)) ? acc_q + ONE : acc_q;
  assign len_d       = (epoch_len == '0) ? ONE : epoch_len;

  assign W1          = w1_q;
  assign W2          = w2_q;
  assign W3          = w3_q;
  assign DE1         = de_q[0];
  assign DE2         = de_q[1];
  assign DE3         = de_q[2];
  assign set_idx     = set_idx_q;
  assign spike_count = spike_count_q;

  // Descending scans so the lowest index / nearest circular successor wins.
  always_comb begin
    any_set   = 1'b0;
    first_idx = '0;
    for (int j = NSETS - 1; j >= 0; j--) begin
      if (tab_de_q[j] != 3'b000) begin
        any_set   = 1'b1;
        first_idx = AW'(j);
      end
    end
    next_idx = set_idx_q;
    cand     = '0;
    for (int j = NSETS - 1; j >= 1; j--) begin
      cand = set_idx_q + AW'(j);
      if (tab_de_q[cand] != 3'b000) next_idx = cand;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < NSETS; i++) begin
        tab_w1_q[i] <= '0;
        tab_w2_q[i] <= '0;
        tab_w3_q[i] <= '0;
        tab_de_q[i] <= '0;
      end
    end else if (wr_ok) begin
      tab_w1_q[cfg_addr] <= cfg_w1;
      tab_w2_q[cfg_addr] <= cfg_w2;
      tab_w3_q[cfg_addr] <= cfg_w3;
      tab_de_q[cfg_addr] <= cfg_de;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q       <= S_IDLE;
      set_idx_q     <= '0;
      cnt_q         <= '0;
      acc_q         <= '0;
      spike_count_q <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      w3_q          <= '0;
      de_q          <= '0;
    end else if (busy && stop) begin
      // Abort drops the partial epoch but keeps the last completed count.
      state_q   <= S_IDLE;
      set_idx_q <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      w3_q      <= '0;
      de_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop && any_set) begin
            state_q   <= S_APPLY;
            set_idx_q <= first_idx;
            w1_q      <= tab_w1_q[first_idx];
            w2_q      <= tab_w2_q[first_idx];
            w3_q      <= tab_w3_q[first_idx];
            de_q      <= tab_de_q[first_idx];
          end
        end
        S_APPLY: begin
          state_q <= S_RUN;
          cnt_q   <= len_d;
        end
        S_RUN: begin
          cnt_q <= cnt_q - ONE;
          acc_q <= acc_d;
          if (cnt_q == ONE) begin
            spike_count_q <= acc_d;
            acc_q         <= '0;
            state_q       <= S_APPLY;
            set_idx_q     <= next_idx;
            w1_q          <= tab_w1_q[next_idx];
            w2_q          <= tab_w2_q[next_idx];
            w3_q          <= tab_w3_q[next_idx];
            de_q          <= tab_de_q[next_idx];
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/neuron_weight_sequencer.md
Name: neuron_weight_sequencer

Overview:
Controller that drives the weight and dendrite-enable inputs (W1..W3, DE1..DE3) of one neuron instance. It holds a small table of weight sets, written by a host port. When running, it applies each non-empty set for a programmable epoch and counts the neuron's output spikes per epoch. This replaces hand-timed weight changes in benches and gives a reusable weight scheduler for neuron arrays.

Parameters:
WW, 4, weight width per dendrite
NSETS, 4, number of weight-set table entries (power of 2)
EPW, 8, width of epoch length and spike counter

Ports:
Clk  input  1  system clock, rising edge
Rst  input  1  asynchronous reset, active-high
cfg_we  input  1  host write request for one table entry
cfg_addr  input  log2(NSETS)  table entry index
cfg_w1, cfg_w2, cfg_w3  input  WW each  weights to store
cfg_de  input  3  dendrite enables to store; bit0 is DE1
cfg_ready  output  1  write accepted this cycle when cfg_we && cfg_ready
epoch_len  input  EPW  RUN length in cycles; sampled on entry to APPLY
start  input  1  begin sequencing
stop  input  1  abort sequencing
spike_in  input  1  neuron OUT_PULSE
W1, W2, W3  output  WW each  weights driven to the neuron
DE1, DE2, DE3  output  1 each  dendrite enables driven to the neuron
set_idx  output  log2(NSETS)  active table entry
busy  output  1  high in APPLY or RUN
epoch_done  output  1  one-cycle pulse at the end of each epoch
spike_count  output  EPW  spikes counted in the last completed epoch

Behaviour:
- Reset (async, Rst=1): all table entries are 0. All outputs are 0. cfg_ready=1. FSM goes to IDLE.
- Entry is empty when its de==3'b000. Empty entries are skipped.
- next(i) is the first non-empty entry after i, searching circularly; it is i itself if i is the only non-empty entry.
- IDLE:
  - W* = 0, DE* = 0, busy = 0.
  - start with at least one non-empty entry: set_idx <= first non-empty entry from 0, go to APPLY.
  - start with all entries empty: ignored.
- APPLY (exactly 1 cycle):
  - Drives W*/DE* from entry set_idx.
  - Loads the cycle counter with max(epoch_len, 1).
  - spike_in is ignored. Go to RUN.
- RUN:
  - Drives entry set_idx. Counter decrements each cycle.
  - Each cycle with spike_in=1 increments the epoch accumulator, saturating at 2^EPW-1.
  - On the cycle the counter equals 1:
    - epoch_done=1 for that cycle.
    - spike_count <= accumulator, including this cycle's spike_in.
    - Accumulator <= 0.
    - set_idx <= next(set_idx). Go to APPLY.
  - RUN therefore lasts exactly max(epoch_len, 1) cycles. Epoch period is RUN length + 1.
- W*/DE* change only on the APPLY entry edge, or to 0 on IDLE entry.
- stop, in APPLY or RUN: next state is IDLE.
  - Outputs go to 0. No epoch_done.
  - spike_count keeps its last completed value. Accumulator is cleared.
- start and stop in the same cycle: stop wins. start while busy is ignored.
- Host write arbitration: cfg_ready=0 only when busy=1 and cfg_addr==set_idx. The active entry cannot change mid-epoch.
  - A write to any other entry completes in 1 cycle.
  - A write accepted on a cycle is visible to next() from the following cycle.
  - Writing an entry empty while it is inactive causes it to be skipped from then on.
- All entries empty while busy (by writes to inactive entries): the current set finishes its epoch, and next() returns the current index.
- Rst asserted mid-epoch: immediate return to reset values. No epoch_done.

Test Plan:
- Reset, then write entry 0 = {8,4,15,de=111}, entry 1 = {7,3,7,111}, entries 2-3 empty. epoch_len=10, pulse start:
  - W=8/4/15 from the cycle after APPLY entry.
  - epoch_done every 11 cycles.
  - set_idx sequence 0,1,0,1.
- spike_in high for 4 RUN cycles of epoch 0, including the last cycle → spike_count=4 in the cycle after epoch_done.
- spike_in held high with epoch_len=255, EPW=8 → spike_count=255 (saturation). epoch_len=0 → RUN lasts 1 cycle, period 2.
- While busy on set 1:
  - cfg_we to addr 1 → cfg_ready=0, entry unchanged.
  - cfg_we to addr 2 with de=001 → accepted; sequence becomes 1,2,0,1.
- start and stop asserted together from IDLE → stays IDLE. stop mid-RUN → next cycle W*=0, DE*=0, busy=0, no epoch_done.
- Rst pulse mid-RUN (asynchronous, between edges) → outputs 0 immediately. The table reads back empty, so a subsequent start with no writes is ignored.
